// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter driving the select of a shared 4:1 datapath mux.
// Grants are held until done, withdrawal or a MAX_HOLD-cycle timeout.
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req_i,
    input  logic       done_i,
    output logic [3:0] grant_o,
    output logic [1:0] select_o,
    output logic       busy_o,
    output logic       timeout_o
);

    localparam int unsigned CntW = $clog2(MAX_HOLD) + 1;
    localparam logic [CntW-1:0] HoldLast = CntW'(MAX_HOLD - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state;
    logic [1:0]      last;
    logic [CntW-1:0] hold_cnt;

    logic [1:0] winner;
    logic       any_req;

    // Scan from the requester after the last winner so priority rotates.
    always_comb begin
        winner  = 2'd0;
        any_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            logic [1:0] idx;
            idx = last + 2'(i);
            if (!any_req && req_i[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            grant_o   <= 4'b0000;
            select_o  <= 2'd0;
            busy_o    <= 1'b0;
            timeout_o <= 1'b0;
            last      <= 2'd3;
            hold_cnt  <= '0;
        end else begin
            timeout_o <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (any_req) begin
                        state    <= StGrant;
                        grant_o  <= 4'b0001 << winner;
                        select_o <= winner;
                        busy_o   <= 1'b1;
                        last     <= winner;
                        hold_cnt <= '0;
                    end
                end
                StGrant: begin
                    // select_o is kept on release so the mux output stays stable.
                    if (done_i || !req_i[select_o]) begin
                        state   <= StIdle;
                        grant_o <= 4'b0000;
                        busy_o  <= 1'b0;
                    end else if (hold_cnt == HoldLast) begin
                        state     <= StIdle;
                        grant_o   <= 4'b0000;
                        busy_o    <= 1'b0;
                        timeout_o <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed self-checking bench for rr_arbiter4 with MAX_HOLD=4.
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_i;
    logic       done_i;
    logic [3:0] grant_o;
    logic [1:0] select_o;
    logic       busy_o;
    logic       timeout_o;

    int checks = 0;
    int errors = 0;

    rr_arbiter4 #(.MAX_HOLD(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_i    (req_i),
        .done_i   (done_i),
        .grant_o  (grant_o),
        .select_o (select_o),
        .busy_o   (busy_o),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                             input logic t);
        check({tag, " grant"}, 8'(grant_o), 8'(g));
        check({tag, " select"}, 8'(select_o), 8'(s));
        check({tag, " busy"}, 8'(busy_o), 8'(|g));
        check({tag, " timeout"}, 8'(timeout_o), 8'(t));
    endtask

    initial begin
        logic [1:0] order [6];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        reset = 1'b1; req_i = 4'b0000; done_i = 1'b0;
        tick(); tick();
        check_out("reset", 4'b0000, 2'd0, 1'b0);

        // Single request, then done
        reset = 1'b0; req_i = 4'b0100;
        tick();
        check_out("single grant", 4'b0100, 2'd2, 1'b0);
        done_i = 1'b1;
        tick();
        check_out("single release", 4'b0000, 2'd2, 1'b0);
        req_i = 4'b0000;
        tick();
        check_out("done in idle", 4'b0000, 2'd2, 1'b0);
        done_i = 1'b0;
        tick();

        // Fairness from a fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0; req_i = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_out($sformatf("rr grant %0d", k), 4'b0001 << order[k], order[k], 1'b0);
            done_i = 1'b1;
            tick();
            check_out($sformatf("rr idle %0d", k), 4'b0000, order[k], 1'b0);
            done_i = 1'b0;
        end

        // Last winner was 1; only requester 0 asks, rotation wraps
        req_i = 4'b0001;
        tick();
        check_out("wrap grant", 4'b0001, 2'd0, 1'b0);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;

        // Timeout: grant held exactly 4 cycles
        req_i = 4'b0010;
        tick();
        check_out("to hold 1", 4'b0010, 2'd1, 1'b0);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check_out($sformatf("to hold %0d", k), 4'b0010, 2'd1, 1'b0);
        end
        tick();
        check_out("to release", 4'b0000, 2'd1, 1'b1);
        tick();
        check_out("to regrant", 4'b0010, 2'd1, 1'b0);
        tick(); tick(); tick();
        check_out("to 4th cycle", 4'b0010, 2'd1, 1'b0);
        done_i = 1'b1;
        tick();
        check_out("done beats timeout", 4'b0000, 2'd1, 1'b0);
        done_i = 1'b0; req_i = 4'b0000;
        tick();
        check_out("no late timeout", 4'b0000, 2'd1, 1'b0);

        // Withdrawal by requester 3
        req_i = 4'b1000;
        tick();
        check_out("wd grant", 4'b1000, 2'd3, 1'b0);
        req_i = 4'b0001;
        tick();
        check_out("wd release", 4'b0000, 2'd3, 1'b0);
        tick();
        check_out("wd next", 4'b0001, 2'd0, 1'b0);
        req_i = 4'b0000;
        tick();

        // Reset mid-grant
        req_i = 4'b1000;
        tick();
        check_out("mid grant", 4'b1000, 2'd3, 1'b0);
        reset = 1'b1;
        tick();
        check_out("mid reset", 4'b0000, 2'd0, 1'b0);
        reset = 1'b0; req_i = 4'b1001;
        tick();
        check_out("post reset", 4'b0001, 2'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares one datapath resource (a 32-bit `mux4to1`-fed port, e.g. the memory/writeback bus) between four masters. It grants one requester at a time, drives the 2-bit `select` of the shared `mux4to1` to route the winner's data, and holds the grant until the transaction completes, the requester withdraws, or a hold timeout expires. Rotating priority guarantees no requester starves.

## Interface
- `MAX_HOLD`, default 16: maximum cycles a grant may be held before forced release. Legal range 2..255.
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `req_i`  input  4  request vector; bit k = requester k wants the resource.
- `done_i`  input  1  single-cycle pulse from the shared resource: current transaction finished.
- `grant_o`  output  4  one-hot grant; all-zero when no grant is active.
- `select_o`  output  2  binary index of the granted requester; connects to `mux4to1.select`.
- `busy_o`  output  1  high while a grant is active (equals `|grant_o`).
- `timeout_o`  output  1  one-cycle pulse when a grant is force-released by `MAX_HOLD`.

## Operation
- Two states: IDLE and GRANT. Hold counter `hold_cnt` is `$clog2(MAX_HOLD)+1` bits wide; `last` is a 2-bit pointer to the most recent winner.
- Reset takes effect on the first rising edge with `reset`=1 and overrides every other input, including mid-grant:
  - state=IDLE, `grant_o`=0, `select_o`=0, `busy_o`=0, `timeout_o`=0.
  - `last`=3, so requester 0 has highest priority first; `hold_cnt`=0.
- IDLE with `req_i`=0: remain in IDLE.
- IDLE with `req_i`≠0: the winner is the first set bit scanning (last+1), (last+2), (last+3), (last+4), all mod 4.
  - At the edge: state=GRANT, `grant_o`=one-hot(winner), `select_o`=winner, `last`=winner, `hold_cnt`=0.
- GRANT, evaluated each edge in this priority order:
  1. `done_i`=1: release, go to IDLE, no timeout pulse. `done_i` wins even when the timeout fires in the same cycle.
  2. `req_i[select_o]`=0 (requester withdrew): release, go to IDLE, no timeout pulse.
  3. `hold_cnt`=MAX_HOLD-1: release, go to IDLE, `timeout_o`=1 for exactly the next cycle.
  4. Otherwise: `hold_cnt` increments and the grant holds.
- Release clears `grant_o` and `busy_o`. `select_o` keeps the last winner so the shared mux output stays stable while IDLE.
- Requests from other masters during GRANT are ignored until the arbiter returns to IDLE. There is no preemption.
- `done_i` seen in IDLE is ignored.
- `grant_o` is never multi-hot and is never nonzero outside GRANT.

## Timing
- All outputs are registered. No combinational path exists from inputs to outputs.
- Grant latency: `req_i` first sampled high at edge N gives `grant_o` valid after edge N (cycle N+1).
- Release: `done_i` sampled at edge M drops `grant_o` after edge M.
- The arbiter spends one mandatory IDLE cycle between grants. The next grant is visible after edge M+1.
- Back-to-back transactions therefore cost grant + at least 1 busy cycle + 1 idle cycle.
- Maximum hold: a grant issued at edge N with no `done_i` or withdrawal is force-released at edge N+MAX_HOLD. `timeout_o` is high for the cycle after that edge.
- Worst-case wait for a continuously requesting master: 3 × (MAX_HOLD + 1) cycles plus 1.

## Test plan
- Reset then single request:
  - Stimulus: `reset`=1 for 2 cycles, then `req_i`=4'b0100.
  - Response: `grant_o`=4'b0100 and `select_o`=2 one cycle after the request is sampled.
  - On `done_i` pulse: `grant_o`=0, `select_o` stays 2.
- Round-robin fairness:
  - Stimulus: `req_i`=4'b1111 held; `done_i` pulsed one cycle after each grant.
  - Response: grant order 0,1,2,3,0,1, each separated by exactly one IDLE cycle.
- Rotation skips idle requesters:
  - Stimulus: after a grant to 1, `req_i`=4'b0001 only.
  - Response: next grant goes to 0 (wraps past 2 and 3).
- Timeout with `MAX_HOLD`=4:
  - Stimulus: `req_i`=4'b0010 held, no `done_i`.
  - Response: `grant_o`=4'b0010 for exactly 4 cycles, then 0, with `timeout_o` a 1-cycle pulse.
  - Simultaneous `done_i` on the 4th cycle: no `timeout_o`.
- Withdrawal:
  - Stimulus: requester 3 granted, then `req_i[3]` dropped while `req_i[0]`=1.
  - Response: `grant_o`=0 after the next edge, then `grant_o`=4'b0001 one cycle later; `timeout_o` stays 0.
- Reset mid-grant:
  - Stimulus: `reset`=1 for 1 cycle while `grant_o`=4'b1000.
  - Response: all outputs are 0 next cycle.
  - With `req_i`=4'b1001 afterwards: the first grant goes to 0.
